// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encoding and defaults for the UART TX arbiter
package uart_tx_arbiter_pkg;

   // Arbiter FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   localparam int DEFAULT_DATA_BITS      = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rtl/uart_tx_arbiter_rr_priority_picker.sv - combinational round-robin picker starting at a pointer
module rr_priority_picker #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] pointer,
   output logic [N_REQ-1:0] grant,
   output logic             valid
);

   localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N_REQ);

   logic [PTR_W:0] idx;

   // Scan requesters from the pointer upward with wraparound; first hit wins
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, pointer} + (PTR_W+1)'(i);
         if (idx >= N_W) begin
            idx = idx - N_W;
         end
         if (!valid && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter; optional watchdog via TX_ARB_TIMEOUT_EN
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int DATA_BITS      = DEFAULT_DATA_BITS,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*DATA_BITS-1:0] i_data,
   output logic [N_REQ-1:0]         o_grant,
   output logic [N_REQ-1:0]         o_ack,
   output logic                     o_tx_start,
   output logic [DATA_BITS-1:0]     o_tx_data,
   input  logic                     i_tx_done,
   output logic                     o_busy,
   output logic                     o_timeout
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("uart_tx_arbiter: N_REQ must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES must be positive");
   end

   arb_state_t           state, state_next;
   logic [PTR_W-1:0]     pointer, pointer_next;
   logic [PTR_W-1:0]     owner, owner_next;
   logic [N_REQ-1:0]     pick_grant;
   logic                 pick_valid;
   logic [PTR_W-1:0]     pick_idx;
   logic [DATA_BITS-1:0] pick_data;
   logic [N_REQ-1:0]     grant_next, ack_next;
   logic                 start_next, busy_next, timeout_next;
   logic [DATA_BITS-1:0] data_next;
   logic [PTR_W-1:0]     owner_inc;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt, cnt_next;
`endif

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req     (i_req),
      .pointer (pointer),
      .grant   (pick_grant),
      .valid   (pick_valid)
   );

   // Encode the one-hot winner to an index and select its character slice
   always_comb begin
      pick_idx  = '0;
      pick_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_grant[k]) begin
            pick_idx  = PTR_W'(k);
            pick_data = i_data[k*DATA_BITS +: DATA_BITS];
         end
      end
   end

   assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_next   = state;
      pointer_next = pointer;
      owner_next   = owner;
      grant_next   = o_grant;
      data_next    = o_tx_data;
      ack_next     = '0;
      start_next   = 1'b0;
      timeout_next = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      cnt_next     = cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               owner_next = pick_idx;
               grant_next = pick_grant;
               data_next  = pick_data;
               start_next = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            state_next = ST_WAIT;
`ifdef TX_ARB_TIMEOUT_EN
            cnt_next   = '0;
`endif
         end
         ST_WAIT: begin
            if (i_tx_done) begin
               ack_next     = o_grant;
               pointer_next = owner_inc;
               grant_next   = '0;
               state_next   = ST_IDLE;
            end
`ifdef TX_ARB_TIMEOUT_EN
            else if (cnt == CNT_LIMIT) begin
               timeout_next = 1'b1;
               pointer_next = owner_inc;
               grant_next   = '0;
               state_next   = ST_IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
`endif
         end
         default: begin
            grant_next = '0;
            state_next = ST_IDLE;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // State and registered outputs; reset aborts any transfer without an ack
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         pointer    <= '0;
         owner      <= '0;
         o_grant    <= '0;
         o_ack      <= '0;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
         o_busy     <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
         o_timeout  <= 1'b0;
         cnt        <= '0;
`endif
      end else begin
         state      <= state_next;
         pointer    <= pointer_next;
         owner      <= owner_next;
         o_grant    <= grant_next;
         o_ack      <= ack_next;
         o_tx_start <= start_next;
         o_tx_data  <= data_next;
         o_busy     <= busy_next;
`ifdef TX_ARB_TIMEOUT_EN
         o_timeout  <= timeout_next;
         cnt        <= cnt_next;
`endif
      end
   end

`ifndef TX_ARB_TIMEOUT_EN
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  grant, ack;
   logic        tx_start, tx_done, busy, timeout;
   logic [7:0]  tx_data;

   int total = 0;
   int bad   = 0;

   uart_tx_arbiter #(
      .N_REQ          (4),
      .DATA_BITS      (8),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req      (req),
      .i_data     (data),
      .o_grant    (grant),
      .o_ack      (ack),
      .o_tx_start (tx_start),
      .o_tx_data  (tx_data),
      .i_tx_done  (tx_done),
      .o_busy     (busy),
      .o_timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      tx_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Advance until o_tx_start is seen (bounded); reports ticks taken
   task automatic wait_start(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (tx_start) begin
            ok = 1'b1;
            n  = i;
            break;
         end
      end
   endtask

   task automatic pulse_done;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = '0;
      tx_done = 1'b0;
      tick();
      total++;
      if ({grant, ack, tx_start, tx_data, busy, timeout} !== 19'd0) begin
         bad++;
         $display("FAIL reset_outputs: got grant=%b ack=%b start=%b data=%h busy=%b to=%b, want all 0",
                  grant, ack, tx_start, tx_data, busy, timeout);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single;
      bit ok; int n;
      do_reset();
      req = 4'b0100;
      wait_start(ok, n);
      total++;
      if (!ok || n != 1 || tx_data !== 8'hA5 || grant !== 4'b0100 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_start: ok=%0d lat=%0d data=%h grant=%b busy=%b, want lat=1 data=a5 grant=0100 busy=1",
                  ok, n, tx_data, grant, busy);
      end
      req = '0;
      tick();
      total++;
      if (tx_start !== 1'b0 || grant !== 4'b0100) begin
         bad++;
         $display("FAIL single_start_width: start=%b grant=%b, want 0 / 0100", tx_start, grant);
      end
      tick();
      pulse_done();
      total++;
      if (ack !== 4'b0100 || grant !== 4'b0000) begin
         bad++;
         $display("FAIL single_ack: ack=%b grant=%b, want 0100 / 0000", ack, grant);
      end
      tick();
      total++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_pulse: ack=%b busy=%b, want 0000 / 0", ack, busy);
      end
   endtask

   task automatic test_fairness;
      bit ok; int n;
      logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [7:0] exp_d [5] = '{8'h11, 8'h3C, 8'hA5, 8'hD3, 8'h11};
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_start(ok, n);
         total++;
         if (!ok || n != 1 || grant !== exp_g[i] || tx_data !== exp_d[i]) begin
            bad++;
            $display("FAIL fair_grant[%0d]: ok=%0d lat=%0d grant=%b data=%h, want lat=1 grant=%b data=%h",
                     i, ok, n, grant, tx_data, exp_g[i], exp_d[i]);
         end
         tick();
         tick();
         pulse_done();
         total++;
         if (ack !== exp_g[i]) begin
            bad++;
            $display("FAIL fair_ack[%0d]: ack=%b, want %b", i, ack, exp_g[i]);
         end
      end
      req = '0;
      tick();
      tick();
      pulse_done();
      tick();
   endtask

   task automatic test_mid_request;
      bit ok; int n;
      do_reset();
      req = 4'b0010;
      wait_start(ok, n);
      tick();
      req = 4'b1010;
      tick();
      tick();
      total++;
      if (!ok || grant !== 4'b0010 || tx_data !== 8'h3C || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_hold: ok=%0d grant=%b data=%h busy=%b, want 0010 / 3c / 1", ok, grant, tx_data, busy);
      end
      pulse_done();
      total++;
      if (ack !== 4'b0010) begin
         bad++;
         $display("FAIL mid_ack1: ack=%b, want 0010", ack);
      end
      wait_start(ok, n);
      total++;
      if (!ok || grant !== 4'b1000 || tx_data !== 8'hD3) begin
         bad++;
         $display("FAIL mid_next: ok=%0d grant=%b data=%h, want 1000 / d3", ok, grant, tx_data);
      end
      req = '0;
      tick();
      pulse_done();
      total++;
      if (ack !== 4'b1000) begin
         bad++;
         $display("FAIL mid_ack3: ack=%b, want 1000", ack);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      bit ok; int n; int acks;
      do_reset();
      req = 4'b0100;
      wait_start(ok, n);
      req = '0;
      tick();
      pulse_done();
      req = 4'b0010;
      wait_start(ok, n);
      req = '0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({grant, ack, tx_start, tx_data, busy, timeout} !== 19'd0) begin
         bad++;
         $display("FAIL reset_mid_async: grant=%b ack=%b start=%b data=%h busy=%b to=%b, want all 0",
                  grant, ack, tx_start, tx_data, busy, timeout);
      end
      tick();
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         if (ack !== 4'b0000 || busy !== 1'b0) acks++;
         tick();
      end
      total++;
      if (acks != 0) begin
         bad++;
         $display("FAIL reset_mid_noack: %0d cycles with ack/busy set, want 0", acks);
      end
      req = 4'b1111;
      wait_start(ok, n);
      total++;
      if (!ok || grant !== 4'b0001) begin
         bad++;
         $display("FAIL reset_mid_pointer: ok=%0d grant=%b, want 0001", ok, grant);
      end
      req = '0;
      tick();
      pulse_done();
      tick();
   endtask

   task automatic test_spurious_done;
      do_reset();
      pulse_done();
      total++;
      if (ack !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
         bad++;
         $display("FAIL spurious_idle: ack=%b busy=%b grant=%b, want 0000 / 0 / 0000", ack, busy, grant);
      end
      req = 4'b0001;
      tick();
      req = '0;
      pulse_done();
      total++;
      if (ack !== 4'b0000 || busy !== 1'b1 || grant !== 4'b0001 || tx_start !== 1'b0) begin
         bad++;
         $display("FAIL spurious_start: ack=%b busy=%b grant=%b start=%b, want 0000 / 1 / 0001 / 0",
                  ack, busy, grant, tx_start);
      end
      tick();
      tick();
      total++;
      if (busy !== 1'b1 || ack !== 4'b0000) begin
         bad++;
         $display("FAIL spurious_still_wait: busy=%b ack=%b, want 1 / 0000", busy, ack);
      end
      pulse_done();
      total++;
      if (ack !== 4'b0001) begin
         bad++;
         $display("FAIL spurious_real_ack: ack=%b, want 0001", ack);
      end
      tick();
   endtask

   task automatic test_timeout;
      bit ok; int n; int seen; int acks;
      do_reset();
      req = 4'b0011;
      wait_start(ok, n);
`ifdef TX_ARB_TIMEOUT_EN
      seen = 0;
      acks = 0;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (ack !== 4'b0000) acks++;
         if (timeout === 1'b1) begin
            seen = i;
            break;
         end
      end
      total++;
      if (seen != 51 || acks != 0 || grant !== 4'b0000) begin
         bad++;
         $display("FAIL timeout_pulse: seen at tick %0d acks=%0d grant=%b, want tick 51, 0 acks, 0000",
                  seen, acks, grant);
      end
      tick();
      total++;
      if (timeout !== 1'b0 || tx_start !== 1'b1 || grant !== 4'b0010) begin
         bad++;
         $display("FAIL timeout_next: to=%b start=%b grant=%b, want 0 / 1 / 0010", timeout, tx_start, grant);
      end
`else
      seen = 0;
      acks = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (timeout !== 1'b0) seen++;
         if (ack !== 4'b0000 || busy !== 1'b1) acks++;
      end
      total++;
      if (seen != 0 || acks != 0 || grant !== 4'b0001) begin
         bad++;
         $display("FAIL no_timeout_wait: timeout cycles=%0d idle/ack cycles=%0d grant=%b, want 0 / 0 / 0001",
                  seen, acks, grant);
      end
`endif
      req = '0;
      tick();
      pulse_done();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      tx_done = 1'b0;
      data = {8'hD3, 8'hA5, 8'h3C, 8'h11};
      test_reset();
      test_single();
      test_fairness();
      test_mid_request();
      test_reset_mid();
      test_spurious_done();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter DATA_BITS, default 8: character width, equal to the transmitter's width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000: watchdog limit in clocks, used only with TX_ARB_TIMEOUT_EN.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock; all logic rising-edge.
REQ-006 i_reset  in  1  asynchronous active-high reset.
REQ-007 i_req  in  N_REQ  per-requester send request, level.
REQ-008 i_data  in  N_REQ*DATA_BITS  packed characters; requester k uses bits [k*DATA_BITS +: DATA_BITS].
REQ-009 o_grant  out  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-010 o_ack  out  N_REQ  one-cycle pulse to the owner when its character is fully sent.
REQ-011 o_tx_start  out  1  one-cycle start strobe to the transmitter.
REQ-012 o_tx_data  out  DATA_BITS  latched character to the transmitter.
REQ-013 i_tx_done  in  1  one-cycle done pulse from the transmitter.
REQ-014 o_busy  out  1  high in any state other than IDLE.
REQ-015 o_timeout  out  1  one-cycle watchdog-abort pulse.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, START, WAIT.
REQ-017 In IDLE with any i_req bit set, SHALL select the winner round-robin, starting at the rotating pointer; it SHALL latch the winner index and its i_data slice, set o_grant, and go to START.
REQ-018 In START, SHALL drive o_tx_start high for exactly one cycle, then go to WAIT.
REQ-019 o_tx_start SHALL rise on the clock edge after the IDLE cycle in which the request was sampled.
REQ-020 In WAIT, on i_tx_done, SHALL pulse o_ack for the owner only and set pointer = (owner+1) mod N_REQ; it SHALL clear o_grant and go to IDLE.
REQ-021 o_tx_data and o_grant SHALL stay constant from grant until the cycle after done.
REQ-022 Deassertion of i_req after grant SHALL NOT cancel the transfer.
REQ-023 A requester still requesting after its ack SHALL have the lowest priority at the next arbitration.
REQ-024 i_tx_done outside WAIT SHALL be ignored.
REQ-025 Arbitration SHALL resume in the IDLE cycle following ack; this gives a minimum gap of one cycle between a done pulse and the next o_tx_start.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Reset SHALL force IDLE asynchronously, including mid-transfer.
REQ-028 During reset: pointer=0, o_grant=0, o_ack=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_timeout=0.
REQ-029 An aborted in-flight character SHALL NOT be acked.

Configuration
REQ-030 Macro TX_ARB_TIMEOUT_EN, defined: SHALL count cycles in WAIT. At TIMEOUT_CYCLES without i_tx_done, it SHALL pulse o_timeout, withhold o_ack, advance the pointer past the owner, and go to IDLE.
REQ-031 TX_ARB_TIMEOUT_EN undefined: no counter SHALL be synthesized, o_timeout SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (2 bits), the default DATA_BITS, and the default TIMEOUT_CYCLES.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_priority_picker; its inputs are the request vector and pointer, and its outputs are a one-hot grant and a valid flag.

Verification
REQ-034 Single request: i_req=4'b0100, slice 2=8'hA5. Required: o_tx_start one cycle later, o_tx_data=8'hA5; after i_tx_done, o_ack=4'b0100 for one cycle.
REQ-035 Fairness: i_req=4'b1111 held for four transfers. Required: grant order 0,1,2,3, then 0 again.
REQ-036 Mid-transfer request: i_req[3] set while requester 1 is in WAIT. Required: o_grant and o_tx_data unchanged; requester 3 is served next.
REQ-037 Reset mid-transfer: i_reset asserted in WAIT. Required: all outputs 0 immediately, no o_ack, pointer=0.
REQ-038 Timeout, with TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, no i_tx_done: o_timeout pulses at cycle 50 of WAIT, no o_ack, next grant goes to the next requester.
REQ-039 Spurious i_tx_done pulses in IDLE and START: no o_ack and no state change.
